gate_vector_driver: RTL and testbench



---
 rtl/gate_drv_pkg.sv | 17 +
 rtl/gate_vector_driver_settle_timer.sv | 33 +++
 rtl/gate_vector_driver.sv | 119 +++++++++++
 tb/tb_gate_vector_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_drv_pkg.sv
// gate_drv_pkg: shared types and default constants for the gate vector driver.
// Contents: sweep FSM state encoding, default WIDTH / SETTLE values.
// No ports (package only).
package gate_drv_pkg;

  localparam int GATE_DRV_WIDTH  = 5;
  localparam int GATE_DRV_SETTLE = 1;

  // ST_ prefix keeps the state names clear of the SETTLE parameter name.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } gate_drv_state_t;

endpackage

// File: rtl/gate_vector_driver_settle_timer.sv
// settle_timer: counts the hold time of one vector before its response is sampled.
// Ports: clk, rst_n (sync, active-low), load (clear to 0), count (advance),
//        expired (combinational, high on the last count SETTLE-1).
module settle_timer
  import gate_drv_pkg::*;
#(
  parameter int SETTLE = GATE_DRV_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/gate_vector_driver.sv
// gate_vector_driver: sweeps all 2^WIDTH input vectors of an AND gate under test,
// holds each for SETTLE+1 cycles, checks the response and reports pass/err_count/fail_vec.
// Ports: clk, rst_n (sync, active-low), start, vec_out (to gate), gate_in (from gate),
//        busy, done (level), pass, err_count, fail_vec.
// Optional: define GATE_DRIVER_FIRST_FAIL_EN to build first-failing-vector capture;
//           otherwise fail_vec is tied to 0.
module gate_vector_driver
  import gate_drv_pkg::*;
#(
  parameter int WIDTH  = GATE_DRV_WIDTH,
  parameter int SETTLE = GATE_DRV_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] fail_vec
);

  gate_drv_state_t state, state_nxt;

  // vec is the FSM's working vector; vec_out is its registered copy so every
  // output (busy/done/pass/vec_out) lags the state register by one edge.
  logic [WIDTH-1:0] vec;
  logic             expired;
  logic             timer_load;
  logic             accept;
  logic             last_vec;
  logic             mismatch;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_vec = &vec;
  // Case inequality: X or Z from the gate counts as a mismatch.
  assign mismatch = (gate_in !== (&vec_out));

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .count   (state == ST_SETTLE),
    .expired (expired)
  );

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt  = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (expired) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        timer_load = 1'b1;
        state_nxt  = last_vec ? ST_DONE : ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      state   <= state_nxt;
      vec_out <= vec;
      busy    <= (state == ST_SETTLE) || (state == ST_CHECK);
      done    <= (state == ST_DONE);
      pass    <= (state == ST_DONE) && (err_count == '0);
      if (accept) begin
        vec       <= '0;
        err_count <= '0;
      end else if (state == ST_CHECK) begin
        if (mismatch) err_count <= err_count + (WIDTH+1)'(1);
        // All-ones is held through DONE.
        if (!last_vec) vec <= vec + WIDTH'(1);
      end
    end
  end

`ifdef GATE_DRIVER_FIRST_FAIL_EN
  logic             captured;
  logic [WIDTH-1:0] fail_q;

  // Vectors are swept in ascending order, so the first capture is the lowest failure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      captured <= 1'b0;
      fail_q   <= '0;
    end else if (accept) begin
      captured <= 1'b0;
      fail_q   <= '0;
    end else if ((state == ST_CHECK) && mismatch && !captured) begin
      captured <= 1'b1;
      fail_q   <= vec_out;
    end
  end

  assign fail_vec = fail_q;
`else
  assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_gate_vector_driver.sv
module tb_gate_vector_driver;

  localparam int WA = 5;
  localparam int SA = 1;
  localparam int WB = 2;
  localparam int SB = 3;

  logic clk;
  logic rst_n;

  logic          start_a, gate_a, busy_a, done_a, pass_a;
  logic [WA-1:0] vec_a, fail_a;
  logic [WA:0]   err_a;

  logic          start_b, gate_b, busy_b, done_b, pass_b;
  logic [WB-1:0] vec_b, fail_b;
  logic [WB:0]   err_b;

  // Gate under test modelled as a truth table indexed by the driven vector.
  logic tbl_a [0:(1<<WA)-1];
  logic tbl_b [0:(1<<WB)-1];
  assign gate_a = tbl_a[vec_a];
  assign gate_b = tbl_b[vec_b];

  int n_pass  = 0;
  int n_total = 0;

  gate_vector_driver #(.WIDTH(WA), .SETTLE(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a), .gate_in(gate_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fail_a)
  );

  gate_vector_driver #(.WIDTH(WB), .SETTLE(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b), .gate_in(gate_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Expected fail_vec given the lowest failing vector (-1 if none).
  function automatic int exp_fail(input int first);
`ifdef GATE_DRIVER_FIRST_FAIL_EN
    return (first < 0) ? 0 : first;
`else
    return 0;
`endif
  endfunction

  // Reference model: an AND gate is 1 only for the all-ones vector.
  function automatic void model_a(output int errs, output int first);
    errs  = 0;
    first = -1;
    for (int v = 0; v < (1 << WA); v++) begin
      logic expv;
      expv = (v == (1 << WA) - 1);
      if (tbl_a[v] !== expv) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endfunction

  // One sweep on dut_a; start accepted at edge 0. Optional random start
  // pulses while busy must be ignored.
  task automatic sweep_a(input bit extra_starts, output int done_edge,
                         output int busy_cyc, output bit vec_ok);
    int edge_n;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    edge_n    = 0;
    done_edge = -1;
    busy_cyc  = 0;
    vec_ok    = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (done_edge < 0 && edge_n < 400) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      start_a = 1'b0;
      if (busy_a) busy_cyc++;
      if (busy_a && (vec_a !== WA'((edge_n - 1) / (SA + 1)))) vec_ok = 1'b0;
      if (done_a) done_edge = edge_n;
      else if (extra_starts && edge_n < 55) start_a = ($urandom_range(0, 3) == 0);
    end
    start_a = 1'b0;
  endtask

  initial begin
    int  de, bc, errs, first, edge_n, done_b_edge, busy_b_cyc;
    bit  vok, vok_b;

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = (v == (1 << WA) - 1);
    for (int v = 0; v < (1 << WB); v++) tbl_b[v] = (v == (1 << WB) - 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_vec", vec_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_pass", pass_a, 0);
    check("reset_err", err_a, 0);
    check("reset_fail", fail_a, 0);
    rst_n = 1'b1;

    // Correct AND gate.
    sweep_a(1'b0, de, bc, vok);
    check("good_done_edge", de, 65);
    check("good_busy_cycles", bc, 64);
    check("good_vec_seq", vok, 1);
    check("good_err", err_a, 0);
    check("good_pass", pass_a, 1);
    check("good_fail", fail_a, 0);
    repeat (5) @(negedge clk);
    check("done_held", done_a, 1);
    check("done_vec_ones", vec_a, 31);

    // Stuck-at-0.
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = 1'b0;
    sweep_a(1'b0, de, bc, vok);
    check("sa0_done_edge", de, 65);
    check("sa0_err", err_a, 1);
    check("sa0_pass", pass_a, 0);
    check("sa0_fail", fail_a, exp_fail(31));

    // Stuck-at-1.
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = 1'b1;
    sweep_a(1'b0, de, bc, vok);
    check("sa1_err", err_a, 31);
    check("sa1_fail", fail_a, 0);

    // OR gate in place of the AND gate.
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = (v != 0);
    sweep_a(1'b0, de, bc, vok);
    check("or_err", err_a, 30);
    check("or_fail", fail_a, exp_fail(1));
    check("or_pass", pass_a, 0);

    // Randomly faulty gates, with stray start pulses while busy.
    for (int r = 0; r < 5; r++) begin
      for (int v = 0; v < (1 << WA); v++) begin
        tbl_a[v] = (v == (1 << WA) - 1);
        if ($urandom_range(0, 9) == 0) tbl_a[v] = ~tbl_a[v];
      end
      model_a(errs, first);
      sweep_a(1'b1, de, bc, vok);
      check("rand_done_edge", de, 65);
      check("rand_vec_seq", vok, 1);
      check("rand_err", err_a, errs);
      check("rand_pass", pass_a, (errs == 0));
      check("rand_fail", fail_a, exp_fail(first));
    end

    // WIDTH=2, SETTLE=3 instance; starts at edges 5 and 9 must be ignored.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    edge_n      = 0;
    done_b_edge = -1;
    busy_b_cyc  = 0;
    vok_b       = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (done_b_edge < 0 && edge_n < 200) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      start_b = (edge_n == 4) || (edge_n == 8);
      if (busy_b) busy_b_cyc++;
      if (busy_b && (vec_b !== WB'((edge_n - 1) / (SB + 1)))) vok_b = 1'b0;
      if (done_b) done_b_edge = edge_n;
    end
    start_b = 1'b0;
    check("b_done_edge", done_b_edge, 17);
    check("b_busy_cycles", busy_b_cyc, 16);
    check("b_vec_seq", vok_b, 1);
    check("b_err", err_b, 0);
    check("b_pass", pass_b, 1);

    // Reset in the middle of a faulty sweep.
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_vec", vec_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_pass", pass_a, 0);
    check("mid_rst_err", err_a, 0);
    check("mid_rst_fail", fail_a, 0);
    rst_n = 1'b1;
    for (int v = 0; v < (1 << WA); v++) tbl_a[v] = (v == (1 << WA) - 1);
    sweep_a(1'b0, de, bc, vok);
    check("post_rst_done_edge", de, 65);
    check("post_rst_err", err_a, 0);
    check("post_rst_pass", pass_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
